// File: rtl/alu_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the ALU operation sequencer.
package alu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_DIV  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_LAST = 5'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_legal(input logic [4:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between the control unit and the sequencer.
interface alu_op_sequencer_if #(parameter int unsigned WORD = 32);

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [WORD-1:0] in_a;
  logic [WORD-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] res_lo;
  logic [WORD-1:0] res_hi;
  logic            res_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, res_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, res_lo, res_hi, res_err
  );

endinterface

// File: rtl/alu_lat_counter.sv
// Loadable down-counter with zero flag; saturates at zero rather than wrapping.
module alu_lat_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time through the ALU: holds operands for the op's
// latency, captures ALU_low/ALU_high and presents the result over valid/ready.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WORD    = 32,
  parameter int unsigned LAT_ALU = 2,
  parameter int unsigned LAT_DIV = 4,
  parameter int unsigned LAT_MUL = 18,
  parameter int unsigned CNT_W   = 5
) (
  input  logic            clk,
  input  logic            clr,
  alu_op_sequencer_if.slave bus,
  output logic [4:0]      alu_sel,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  input  logic [WORD-1:0] alu_low,
  input  logic [WORD-1:0] alu_high,
  output logic            busy
);

  logic [1:0]       state;
  logic             accept;
  logic             op_bad;
  logic             err_pend;
  logic [CNT_W-1:0] lat_val;
  logic             cnt_zero;
  logic [WORD-1:0]  res_lo_q;
  logic [WORD-1:0]  res_hi_q;
  logic             res_err_q;
  logic             out_valid_q;

  assign accept = bus.in_valid && (state == ST_IDLE);
  assign op_bad = !op_legal(bus.in_op) ||
                  ((bus.in_op == OP_DIV) && (bus.in_b == '0));

  // Rejected requests take one RUN cycle so their result appears at k+1,
  // the same timing a one-cycle op would have.
  always_comb begin
    lat_val = '0;
    if (!op_bad) begin
      case (bus.in_op)
        OP_DIV:  lat_val = CNT_W'(LAT_DIV - 1);
        OP_MUL:  lat_val = CNT_W'(LAT_MUL - 1);
        default: lat_val = CNT_W'(LAT_ALU - 1);
      endcase
    end
  end

  alu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .load_val (lat_val),
    .dec      (state == ST_RUN),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= ST_IDLE;
      err_pend    <= 1'b0;
      alu_sel     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      res_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_RUN;
            err_pend <= op_bad;
            if (!op_bad) begin
              alu_sel <= bus.in_op;
              alu_a   <= bus.in_a;
              alu_b   <= bus.in_b;
            end
          end
        end
        ST_RUN: begin
          if (cnt_zero) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            res_err_q   <= err_pend;
            res_lo_q    <= err_pend ? '0 : alu_low;
            res_hi_q    <= err_pend ? '0 : alu_high;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_err   = res_err_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks every
// presented result, its latency, operand hold and handshake behaviour.
module tb_alu_op_sequencer;
  import alu_ctrl_pkg::*;

  localparam int unsigned WORD = 32;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_low, alu_high;
  logic        busy;

  alu_op_sequencer_if #(.WORD(WORD)) bus();

  alu_op_sequencer #(
    .WORD    (WORD),
    .LAT_ALU (2),
    .LAT_DIV (4),
    .LAT_MUL (18),
    .CNT_W   (5)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_low  (alu_low),
    .alu_high (alu_high),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int unsigned lat;
    int unsigned acc;
    logic [4:0]  sel_e;
    logic [31:0] a_e;
    logic [31:0] b_e;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  int          force_lo = 0;
  bit          rand_rdy = 1'b0;
  bit          prev_ov  = 1'b0;
  logic [4:0]  last_sel = '0;
  logic [31:0] last_a   = '0;
  logic [31:0] last_b   = '0;

  // Behaviour of the attached ALU: {ALU_high, ALU_low}.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0]        s;
    logic signed [63:0] xa, xb;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; return {31'd0, s}; end
      5'd1: begin s = {1'b0, a} - {1'b0, b}; return {31'd0, s}; end
      5'd2: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      5'd3: return {b, a & b};
      5'd4: return {b, a | b};
      5'd5: return {b, a ^ b};
      5'd6: begin
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        return xa * xb;
      end
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  always_comb {alu_high, alu_low} = alu_fn(alu_sel, alu_a, alu_b);

  function automatic bit is_err(input logic [4:0] op, input logic [31:0] b);
    return (op > 5'd6) || ((op == 5'd2) && (b == 32'd0));
  endfunction

  function automatic int unsigned lat_of(input logic [4:0] op, input logic [31:0] b);
    if (is_err(op, b)) return 1;
    if (op == 5'd2) return 4;
    if (op == 5'd6) return 18;
    return 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (force_lo > 0) begin
      bus.out_ready = 1'b0;
      force_lo--;
    end else begin
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    #1;
    if (!clr) begin
      if (sbq.size() > 0 && busy) begin
        chk("alu_sel_hold", 64'(alu_sel), 64'(sbq[0].sel_e));
        chk("alu_a_hold",   64'(alu_a),   64'(sbq[0].a_e));
        chk("alu_b_hold",   64'(alu_b),   64'(sbq[0].b_e));
      end
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          if (!prev_ov) chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
          chk("res_lo",  64'(bus.res_lo),  64'(sbq[0].lo));
          chk("res_hi",  64'(bus.res_hi),  64'(sbq[0].hi));
          chk("res_err", 64'(bus.res_err), 64'(sbq[0].err));
          chk("in_ready_while_done", 64'(bus.in_ready), 64'd0);
          if (bus.out_ready) void'(sbq.pop_front());
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble);
    exp_t        e;
    logic [63:0] r;
    int          w;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    w = 0;
    while (!bus.in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    r     = alu_fn(op, a, b);
    e.err = is_err(op, b);
    e.lo  = e.err ? 32'd0 : r[31:0];
    e.hi  = e.err ? 32'd0 : r[63:32];
    e.lat = lat_of(op, b);
    e.acc = cyc;
    if (!e.err) begin
      last_sel = op;
      last_a   = a;
      last_b   = b;
    end
    e.sel_e = last_sel;
    e.a_e   = last_a;
    e.b_e   = last_b;
    sbq.push_back(e);
    bus.in_valid = 1'b0;
    if (scramble) bus.in_a = $urandom;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sbq.size() > 0 || busy) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    clr          = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_alu_sel",   64'(alu_sel),       64'd0);
    chk("rst_alu_a",     64'(alu_a),         64'd0);
    chk("rst_alu_b",     64'(alu_b),         64'd0);
    chk("rst_res",       {bus.res_hi, bus.res_lo}, 64'd0);
    chk("rst_res_err",   64'(bus.res_err),   64'd0);
    clr = 1'b0;

    issue(5'd0, 32'd5, 32'd7, 1'b0);
    wait_idle();
    chk("in_ready_after_add", 64'(bus.in_ready), 64'd1);

    issue(5'd6, 32'hFFFF_FFFD, 32'd4, 1'b0);
    wait_idle();

    issue(5'd2, 32'd100, 32'd0, 1'b0);
    wait_idle();

    force_lo = 8;
    issue(5'd9, 32'd1, 32'd2, 1'b0);
    wait_idle();

    issue(5'd1, 32'd3, 32'd5, 1'b1);
    wait_idle();

    issue(5'd6, $urandom, $urandom, 1'b0);
    repeat (5) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_in_ready",  64'(bus.in_ready),  64'd1);
    chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_busy",      64'(busy),          64'd0);
    chk("clr_alu",       {27'd0, alu_sel, alu_a}, 64'd0);
    chk("clr_alu_b",     64'(alu_b),         64'd0);
    chk("clr_res",       {bus.res_hi, bus.res_lo}, 64'd0);
    sbq.delete();
    last_sel = '0;
    last_a   = '0;
    last_b   = '0;
    @(negedge clk);
    clr = 1'b0;
    repeat (25) @(negedge clk);
    chk("no_result_after_clr", 64'(bus.out_valid), 64'd0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(op, a, b, 1'($urandom_range(0, 1)));
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
